// File: rtl/data_sram_if.sv
// Data-SRAM request/response bundle between the core's EX/MEM stages and a memory responder.
// The core drives the request fields; the responder returns registered read data.
interface data_sram_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_slave.sv
// Data-SRAM responder: word-addressed on-chip RAM plus an MMIO block with LED, switch,
// free-running timer, compare and interrupt-status registers. Read data is registered.
module data_sram_slave #(
  parameter int unsigned RAM_AW  = 12,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  data_sram_if.slave  data_sram,
  input  logic [7:0]  switch_i,
  output logic [15:0] led_o,
  output logic        timer_int_o
);

  localparam logic [13:0] OffLed     = 14'd0;
  localparam logic [13:0] OffSwitch  = 14'd1;
  localparam logic [13:0] OffTimer   = 14'd2;
  localparam logic [13:0] OffCompare = 14'd3;
  localparam logic [13:0] OffIntSts  = 14'd4;

  logic [31:0] r_ram [2**RAM_AW];
  logic [31:0] r_rdata;
  logic [31:0] r_timer;
  logic [31:0] r_compare;
  logic [15:0] r_led;
  logic        r_int;

  logic              w_rd, w_wr, w_mmio;
  logic [13:0]       w_word;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [31:0]       w_ram_q, w_mmio_q, w_rdata_nxt;
  logic              w_wr_led, w_wr_timer, w_wr_compare, w_wr_int, w_int_clr;
  logic [15:0]       w_led_nxt;
  logic [31:0]       w_timer_nxt, w_compare_nxt;
  logic              w_int_nxt;
  logic [1:0]        w_unused_addr;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wr_val[8*i +: 8];
    end
    return res;
  endfunction

  assign w_rd          = data_sram.en && (data_sram.wen == 4'b0000);
  assign w_wr          = data_sram.en && (data_sram.wen != 4'b0000);
  assign w_mmio        = (data_sram.addr[31:16] == MMIO_HI);
  assign w_word        = data_sram.addr[15:2];
  assign w_ram_idx     = data_sram.addr[RAM_AW+1:2];
  assign w_unused_addr = data_sram.addr[1:0];
  assign w_ram_q       = r_ram[w_ram_idx];

  assign w_wr_led     = w_wr && w_mmio && (w_word == OffLed);
  assign w_wr_timer   = w_wr && w_mmio && (w_word == OffTimer);
  assign w_wr_compare = w_wr && w_mmio && (w_word == OffCompare);
  assign w_wr_int     = w_wr && w_mmio && (w_word == OffIntSts);

  // RAM holds no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_wr && !w_mmio) begin
      r_ram[w_ram_idx] <= byte_merge(w_ram_q, data_sram.wdata, data_sram.wen);
    end
  end

  always_comb begin
    w_mmio_q = '0;
    case (w_word)
      OffLed:     w_mmio_q = {16'h0, r_led};
      OffSwitch:  w_mmio_q = {24'h0, switch_i};
      OffTimer:   w_mmio_q = r_timer;
      OffCompare: w_mmio_q = r_compare;
      OffIntSts:  w_mmio_q = {31'h0, r_int};
      default:    w_mmio_q = '0;
    endcase
    w_rdata_nxt = w_mmio ? w_mmio_q : w_ram_q;
  end

  always_comb begin
    w_led_nxt = r_led;
    if (w_wr_led) begin
      if (data_sram.wen[0]) w_led_nxt[7:0]  = data_sram.wdata[7:0];
      if (data_sram.wen[1]) w_led_nxt[15:8] = data_sram.wdata[15:8];
    end
    // A software write to TIMER overrides this cycle's increment.
    w_timer_nxt   = w_wr_timer ? byte_merge(r_timer, data_sram.wdata, data_sram.wen)
                               : r_timer + 32'd1;
    w_compare_nxt = w_wr_compare ? byte_merge(r_compare, data_sram.wdata, data_sram.wen)
                                 : r_compare;
    // Match compares against the pre-write COMPARE and beats a same-cycle clear.
    w_int_clr = w_wr_int && data_sram.wen[0] && data_sram.wdata[0];
    w_int_nxt = (r_timer == r_compare) || (r_int && !w_int_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata   <= '0;
      r_led     <= '0;
      r_timer   <= '0;
      r_compare <= '1;
      r_int     <= 1'b0;
    end else begin
      if (w_rd) r_rdata <= w_rdata_nxt;
      r_led     <= w_led_nxt;
      r_timer   <= w_timer_nxt;
      r_compare <= w_compare_nxt;
      r_int     <= w_int_nxt;
    end
  end

  assign data_sram.rdata = r_rdata;
  assign led_o           = r_led;
  assign timer_int_o     = r_int;

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: directed scenarios plus randomized traffic, all checked against a
// cycle-level reference model of the memory map kept in this file.
module tb_data_sram_slave;
  localparam logic [15:0] MmioHi = 16'hBFAF;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sw;
  logic [15:0] led;
  logic        tint;

  data_sram_if bus();

  data_sram_slave #(.RAM_AW(12), .MMIO_HI(MmioHi)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_sram  (bus),
    .switch_i   (sw),
    .led_o      (led),
    .timer_int_o(tint)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model. TIMER is kept as an anchor value plus elapsed edges.
  logic [31:0] m_ram [int];
  logic [15:0] m_led;
  logic [31:0] m_cmp, m_tbase, m_rdata;
  logic        m_int;
  int          m_cyc = 0;
  int          m_tcyc = 0;

  function automatic logic [31:0] m_timer_now();
    return m_tbase + 32'(m_cyc - m_tcyc);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] old_val, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_led = '0; m_cmp = '1; m_tbase = '0; m_tcyc = m_cyc; m_int = 1'b0; m_rdata = '0;
  endtask

  // Drive one request for one cycle, advance the model by one edge, return at edge+1.
  task automatic cyc(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                     input logic [31:0] wdata);
    logic [31:0] t, tmp;
    logic        hit;
    int          word, ridx;
    bus.en = en; bus.wen = wen; bus.addr = addr; bus.wdata = wdata;
    t    = m_timer_now();
    hit  = (t == m_cmp);
    word = int'(addr[15:2]);
    ridx = int'(addr[13:2]);
    if (en) begin
      if (addr[31:16] == MmioHi) begin
        if (wen == 4'b0000) begin
          case (word)
            0:       m_rdata = {16'h0, m_led};
            1:       m_rdata = {24'h0, sw};
            2:       m_rdata = t;
            3:       m_rdata = m_cmp;
            4:       m_rdata = {31'h0, m_int};
            default: m_rdata = '0;
          endcase
        end else begin
          case (word)
            0: begin tmp = lanes({16'h0, m_led}, wdata, wen & 4'b0011); m_led = tmp[15:0]; end
            2: begin m_tbase = lanes(t, wdata, wen); m_tcyc = m_cyc + 1; end
            3: m_cmp = lanes(m_cmp, wdata, wen);
            4: if (wen[0] && wdata[0]) m_int = 1'b0;
            default: ;
          endcase
        end
      end else if (wen == 4'b0000) begin
        m_rdata = m_ram.exists(ridx) ? m_ram[ridx] : 'x;
      end else begin
        m_ram[ridx] = lanes(m_ram.exists(ridx) ? m_ram[ridx] : 32'h0, wdata, wen);
      end
    end
    if (hit) m_int = 1'b1;
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got %h want %h", bus.rdata, 32'h0); end
    n_checks++; if (led !== 16'h0) begin n_errors++; $display("FAIL reset_led got %h want %h", led, 16'h0); end
    n_checks++; if (tint !== 1'b0) begin n_errors++; $display("FAIL reset_int got %b want 0", tint); end
    cyc(1, 4'h0, {MmioHi, 16'h0008}, 0);
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL reset_timer got %h want %h", bus.rdata, 32'h0); end
    cyc(1, 4'h0, {MmioHi, 16'h000C}, 0);
    n_checks++; if (bus.rdata !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL reset_compare got %h want %h", bus.rdata, 32'hFFFF_FFFF); end
  endtask

  task automatic test_ram_bytes();
    cyc(1, 4'hF, 32'h100, 32'h1122_3344);
    cyc(1, 4'h5, 32'h100, 32'hAABB_CCDD);
    cyc(1, 4'h0, 32'h100, 0);
    n_checks++; if (bus.rdata !== 32'h11BB_33DD) begin n_errors++; $display("FAIL ram_byte_merge got %h want %h", bus.rdata, 32'h11BB_33DD); end
    cyc(1, 4'h0, 32'h4100, 0);
    n_checks++; if (bus.rdata !== 32'h11BB_33DD) begin n_errors++; $display("FAIL ram_alias got %h want %h", bus.rdata, 32'h11BB_33DD); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    cyc(1, 4'hF, 32'h104, 32'hCAFE_F00D);
    exp_q = '{32'h11BB_33DD, 32'hCAFE_F00D, 32'h11BB_33DD};
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'h0, (i == 1) ? 32'h104 : 32'h100, 0);
      n_checks++; if (bus.rdata !== exp_q[i]) begin n_errors++; $display("FAIL b2b_read%0d got %h want %h", i, bus.rdata, exp_q[i]); end
    end
    cyc(0, 4'h0, 32'h104, 0);
    cyc(1, 4'hF, 32'h108, 32'h5555_AAAA);
    n_checks++; if (bus.rdata !== 32'h11BB_33DD) begin n_errors++; $display("FAIL b2b_hold got %h want %h", bus.rdata, 32'h11BB_33DD); end
  endtask

  task automatic test_led_switch();
    cyc(1, 4'hF, {MmioHi, 16'h0000}, 32'hFFFF_1234);
    n_checks++; if (led !== 16'h1234) begin n_errors++; $display("FAIL led_out got %h want %h", led, 16'h1234); end
    cyc(1, 4'h0, {MmioHi, 16'h0000}, 0);
    n_checks++; if (bus.rdata !== 32'h0000_1234) begin n_errors++; $display("FAIL led_read got %h want %h", bus.rdata, 32'h1234); end
    sw = 8'hA5;
    cyc(1, 4'h0, {MmioHi, 16'h0004}, 0);
    n_checks++; if (bus.rdata !== 32'h0000_00A5) begin n_errors++; $display("FAIL switch_read got %h want %h", bus.rdata, 32'hA5); end
    cyc(1, 4'hF, {MmioHi, 16'h0004}, 32'hFFFF_FFFF);
    cyc(1, 4'h0, {MmioHi, 16'h0004}, 0);
    n_checks++; if (bus.rdata !== 32'h0000_00A5) begin n_errors++; $display("FAIL switch_ro got %h want %h", bus.rdata, 32'hA5); end
    n_checks++; if (led !== 16'h1234) begin n_errors++; $display("FAIL led_after_sw_write got %h want %h", led, 16'h1234); end
  endtask

  task automatic test_timer_int();
    logic [31:0] exp_q [$];
    cyc(1, 4'hF, {MmioHi, 16'h000C}, 32'd5);
    cyc(1, 4'h1, {MmioHi, 16'h0010}, 32'd1);
    cyc(1, 4'hF, {MmioHi, 16'h0008}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 4'h0, 0, 0);
      n_checks++; if (tint !== (k >= 6)) begin n_errors++; $display("FAIL int_rise_k%0d got %b want %b", k, tint, (k >= 6)); end
    end
    cyc(1, 4'h1, {MmioHi, 16'h0010}, 32'd1);
    n_checks++; if (tint !== 1'b0) begin n_errors++; $display("FAIL int_clear got %b want 0", tint); end
    cyc(1, 4'hF, {MmioHi, 16'h0008}, 32'hFFFF_FFFE);
    exp_q = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'h0, {MmioHi, 16'h0008}, 0);
      n_checks++; if (bus.rdata !== exp_q[i]) begin n_errors++; $display("FAIL timer_wrap%0d got %h want %h", i, bus.rdata, exp_q[i]); end
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(0, 4'h0, 0, 0);
      n_checks++; if (tint !== (k == 5)) begin n_errors++; $display("FAIL int_rewrap_k%0d got %b want %b", k, tint, (k == 5)); end
    end
  endtask

  task automatic test_simultaneous();
    cyc(1, 4'hF, {MmioHi, 16'h000C}, 32'h202);
    cyc(1, 4'h1, {MmioHi, 16'h0010}, 32'd1);
    cyc(1, 4'hF, {MmioHi, 16'h0008}, 32'h200);
    cyc(0, 4'h0, 0, 0);
    cyc(0, 4'h0, 0, 0);
    cyc(1, 4'h1, {MmioHi, 16'h0010}, 32'd1);
    n_checks++; if (tint !== 1'b1) begin n_errors++; $display("FAIL set_beats_clear got %b want 1", tint); end
    cyc(1, 4'h1, {MmioHi, 16'h0010}, 32'd1);
    n_checks++; if (tint !== 1'b0) begin n_errors++; $display("FAIL clear_after_match got %b want 0", tint); end
    cyc(1, 4'hF, {MmioHi, 16'h0008}, 32'h100);
    cyc(0, 4'h0, 0, 0);
    cyc(1, 4'h0, {MmioHi, 16'h0008}, 0);
    n_checks++; if (bus.rdata !== 32'h101) begin n_errors++; $display("FAIL timer_write_then_count got %h want %h", bus.rdata, 32'h101); end
  endtask

  task automatic test_async_reset();
    cyc(1, 4'hF, {MmioHi, 16'h0000}, 32'h0000_5A5A);
    cyc(1, 4'h0, 32'h100, 0);
    n_checks++; if (bus.rdata !== 32'h11BB_33DD || led !== 16'h5A5A) begin n_errors++; $display("FAIL pre_reset got %h/%h want %h/%h", bus.rdata, led, 32'h11BB_33DD, 16'h5A5A); end
    bus.en = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL async_rdata got %h want %h", bus.rdata, 32'h0); end
    n_checks++; if (led !== 16'h0) begin n_errors++; $display("FAIL async_led got %h want %h", led, 16'h0); end
    n_checks++; if (tint !== 1'b0) begin n_errors++; $display("FAIL async_int got %b want 0", tint); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cyc(1, 4'h0, {MmioHi, 16'h0008}, 0);
    n_checks++; if (bus.rdata !== 32'h0) begin n_errors++; $display("FAIL post_reset_timer got %h want %h", bus.rdata, 32'h0); end
    cyc(1, 4'h0, 32'h100, 0);
    n_checks++; if (bus.rdata !== 32'h11BB_33DD) begin n_errors++; $display("FAIL ram_persist got %h want %h", bus.rdata, 32'h11BB_33DD); end
  endtask

  task automatic test_random();
    logic [31:0] hi, a, d;
    int          sel, idx, w;
    for (int i = 0; i < 8; i++) cyc(1, 4'hF, 32'h800 + 32'(4 * i), $urandom);
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, 7);
      w   = $urandom_range(0, 7);
      hi  = $urandom;
      if (hi[31:16] == MmioHi) hi[31] = ~hi[31];
      d   = $urandom;
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      if (sel <= 4) begin
        a = {hi[31:16], hi[15:14], 12'(512 + idx), hi[1:0]};
        cyc(1, (sel <= 2) ? 4'h0 : 4'($urandom_range(1, 15)), a, d);
      end else if (sel <= 8) begin
        a = {MmioHi, 14'(w), hi[1:0]};
        if (w == 3 && hi[2]) d = m_timer_now() + 32'($urandom_range(1, 6));
        cyc(1, (sel <= 6) ? 4'h0 : 4'($urandom_range(1, 15)), a, d);
      end else begin
        cyc(0, 4'($urandom), hi, d);
      end
      n_checks++; if (bus.rdata !== m_rdata) begin n_errors++; $display("FAIL rand_rdata@%0d got %h want %h", n, bus.rdata, m_rdata); end
      n_checks++; if (led !== m_led) begin n_errors++; $display("FAIL rand_led@%0d got %h want %h", n, led, m_led); end
      n_checks++; if (tint !== m_int) begin n_errors++; $display("FAIL rand_int@%0d got %b want %b", n, tint, m_int); end
    end
  endtask

  initial begin
    rst = 1'b1;
    sw = 8'h00;
    bus.en = 1'b0; bus.wen = 4'h0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    test_reset();
    test_ram_bytes();
    test_back_to_back();
    test_led_switch();
    test_timer_int();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
